frame_capture_writer: RTL and testbench



---
 rtl/frame_pkg.sv | 21 ++
 rtl/depth_threshold.sv | 13 +
 rtl/frame_capture_writer.sv | 122 ++++++++++++
 tb/tb_frame_capture_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants and types for the depth-frame capture path.
package frame_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam int ADDR_W    = 18;
  localparam int DEPTH_W   = 16;
  localparam int DEF_HSIZE = 512;
  localparam int DEF_VSIZE = 424;

  // ST_ prefix keeps the SYNC1 state distinct from the SYNC1 byte constant.
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/depth_threshold.sv
// Converts one depth sample into a touch-mask bit; zero depth is invalid.
module depth_threshold
  import frame_pkg::*;
(
  input  logic [DEPTH_W-1:0] depth,
  input  logic [DEPTH_W-1:0] near,
  input  logic [DEPTH_W-1:0] far,
  output logic               mask
);

  assign mask = (depth != '0) && (near <= depth) && (depth <= far);

endmodule

// File: rtl/frame_capture_writer.sv
// Parses the sync-prefixed little-endian depth stream and writes the
// thresholded mask into the frame BRAM, pulsing frame_available when done.
module frame_capture_writer
  import frame_pkg::*;
#(
  parameter int HSIZE          = DEF_HSIZE,
  parameter int VSIZE          = DEF_VSIZE,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [DEPTH_W-1:0] depth_near,
  input  logic [DEPTH_W-1:0] depth_far,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               bram_we,
  output logic               bram_din,
  output logic               frame_available,
  output logic               frame_error,
  output logic               busy
);

  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(HSIZE * VSIZE - 1);

  state_t               state, state_next;
  logic                 accept, active, timed_out, last_pix, mask;
  logic                 sync_hit, lo_take, hi_take;
  logic [7:0]           lo_byte;
  logic [DEPTH_W-1:0]   near_q, far_q, depth;
  logic [ADDR_W-1:0]    pix_cnt;
  logic [TO_W-1:0]      idle_cnt;

  assign accept    = rx_valid & rx_ready;
  assign active    = (state == ST_SYNC1) || (state == ST_LO) || (state == ST_HI);
  assign timed_out = active && (idle_cnt == TO_LIMIT);
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign depth     = {rx_data, lo_byte};

  // A timeout wins over a byte arriving in the same cycle: the frame is dead.
  assign sync_hit = (state == ST_SYNC1) && accept && !timed_out && (rx_data == SYNC1);
  assign lo_take  = (state == ST_LO) && accept && !timed_out;
  assign hi_take  = (state == ST_HI) && accept && !timed_out;

  depth_threshold u_threshold (
    .depth (depth),
    .near  (near_q),
    .far   (far_q),
    .mask  (mask)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_HUNT:
        if (accept && rx_data == SYNC0) state_next = ST_SYNC1;
      ST_SYNC1:
        if (timed_out)                 state_next = ST_HUNT;
        else if (accept) begin
          if (rx_data == SYNC1)        state_next = ST_LO;
          else if (rx_data == SYNC0)   state_next = ST_SYNC1;
          else                         state_next = ST_HUNT;
        end
      ST_LO:
        if (timed_out)                 state_next = ST_HUNT;
        else if (accept)               state_next = ST_HI;
      ST_HI:
        if (timed_out)                 state_next = ST_HUNT;
        else if (accept)               state_next = last_pix ? ST_DONE : ST_LO;
      ST_DONE:                         state_next = ST_HUNT;
      default:                         state_next = ST_HUNT;
    endcase
  end

  always_comb begin
    rx_ready = (state != ST_DONE);
    busy     = (state == ST_LO) || (state == ST_HI) || (state == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      near_q          <= '0;
      far_q           <= '0;
      lo_byte         <= '0;
      pix_cnt         <= '0;
      idle_cnt        <= '0;
      bram_addr       <= '0;
      bram_we         <= 1'b0;
      bram_din        <= 1'b0;
      frame_available <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      bram_we         <= hi_take;
      frame_available <= (state == ST_DONE);
      frame_error     <= timed_out;

      if (active && !accept && !timed_out) idle_cnt <= idle_cnt + 1'b1;
      else                                 idle_cnt <= '0;

      if (sync_hit) begin
        near_q  <= depth_near;
        far_q   <= depth_far;
        pix_cnt <= '0;
      end
      if (lo_take) lo_byte <= rx_data;
      if (hi_take) begin
        bram_addr <= pix_cnt;
        bram_din  <= mask;
        if (!last_pix) pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Bench for frame_capture_writer on a 4x2 frame with a 16-cycle timeout.
module tb_frame_capture_writer;
  import frame_pkg::*;

  localparam int HS = 4;
  localparam int VS = 2;
  localparam int TO = 16;
  localparam int NPIX = HS * VS;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [15:0]       depth_near = '0;
  logic [15:0]       depth_far = '0;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we, bram_din, frame_available, frame_error, busy;

  frame_capture_writer #(.HSIZE(HS), .VSIZE(VS), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .depth_near(depth_near), .depth_far(depth_far),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .frame_available(frame_available), .frame_error(frame_error), .busy(busy)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int fa_count = 0;
  int fe_count = 0;
  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] exp_e;

  typedef struct {
    logic [15:0] near, far, mid_far, w0, w1;
    logic        pre;
    logic        d0, d1;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every BRAM write must match the head of the expected queue.
  always @(negedge clock) begin
    if (frame_available) fa_count++;
    if (frame_error) fe_count++;
    if (bram_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bram_write: unexpected write addr=%0d din=%0b", bram_addr, bram_din);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bram_addr, bram_din} !== exp_e) begin
          n_bad++;
          $display("FAIL bram_write: got addr=%0d din=%0b, required addr=%0d din=%0b",
                   bram_addr, bram_din, exp_e[ADDR_W:1], exp_e[0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 8) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle_gap();
    int g;
    g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    repeat (g) @(negedge clock);
  endtask

  task automatic send_sync(input logic pre);
    if (pre) begin
      send_byte(8'h00);
      send_byte(8'hA5);
      send_byte(8'hA5);
      @(negedge clock);
      check("busy_before_sync", 32'(busy), 32'd0);
    end else begin
      send_byte(8'hA5);
    end
    send_byte(8'h5A);
    @(negedge clock);
    check("busy_after_sync", 32'(busy), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input int idx, input logic din, input logic gaps);
    if (gaps) idle_gap();
    send_byte(w[7:0]);
    exp_q.push_back({ADDR_W'(idx), din});
    send_byte(w[15:8]);
  endtask

  task automatic end_of_frame_check(input int fa_before);
    @(negedge clock);
    check("done_rx_ready", 32'(rx_ready), 32'd0);
    check("fa_early", 32'(frame_available), 32'd0);
    @(negedge clock);
    check("frame_available", 32'(frame_available), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check("hunt_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clock);
    check("fa_one_cycle", 32'(frame_available), 32'd0);
    check("fa_count", 32'(fa_count), 32'(fa_before + 1));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_bram_din", 32'(bram_din), 32'd0);
    check("rst_fa", 32'(frame_available), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fa0, fe0, n;
    vecs[0] = '{16'd400,  16'd1000,  16'd1000,  16'd500, 16'd1500, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'd400,  16'd1000,  16'd1000,  16'd0,   16'd0,    1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'd1000, 16'd400,   16'd400,   16'd700, 16'd700,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'd100,  16'd1000,  16'd200,   16'd600, 16'd600,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'd400,  16'd1000,  16'd1000,  16'd400, 16'd1000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'd400,  16'd1000,  16'd1000,  16'd399, 16'd1001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'd0,    16'd65535, 16'd65535, 16'd0,   16'd1,    1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven full frames; thresholds are disturbed after sync.
    for (int v = 0; v < 7; v++) begin
      fa0 = fa_count;
      depth_near = vecs[v].near;
      depth_far  = vecs[v].far;
      send_sync(vecs[v].pre);
      depth_far  = vecs[v].mid_far;
      depth_near = 16'($urandom_range(0, 65535));
      for (int p = 0; p < NPIX; p++)
        send_word((p % 2 == 0) ? vecs[v].w0 : vecs[v].w1, p,
                  (p % 2 == 0) ? vecs[v].d0 : vecs[v].d1, v != 0);
      end_of_frame_check(fa0);
    end

    // Stream stalls after 3 words: timeout abort, then a clean frame.
    fa0 = fa_count;
    fe0 = fe_count;
    depth_near = 16'd400;
    depth_far  = 16'd1000;
    send_sync(1'b0);
    for (int p = 0; p < 3; p++) send_word(16'd500, p, 1'b1, 1'b0);
    n = 0;
    while (!frame_error && n < 40) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n < 16 || n > 19) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d idle cycles, required 16..19", n);
    end
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("fe_one_cycle", 32'(frame_error), 32'd0);
    check("fe_count", 32'(fe_count), 32'(fe0 + 1));
    check("timeout_no_fa", 32'(fa_count), 32'(fa0));
    check("timeout_queue", 32'(exp_q.size()), 32'd0);
    send_sync(1'b0);
    for (int p = 0; p < NPIX; p++) send_word(16'd1500, p, 1'b0, 1'b1);
    end_of_frame_check(fa0);

    // Reset after 5 pixels abandons the frame without any pulse.
    fa0 = fa_count;
    fe0 = fe_count;
    send_sync(1'b0);
    for (int p = 0; p < 5; p++) send_word(16'd800, p, 1'b1, 1'b0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_no_fa", 32'(fa_count), 32'(fa0));
    check("reset_no_fe", 32'(fe_count), 32'(fe0));
    check("reset_queue", 32'(exp_q.size()), 32'd0);
    send_sync(1'b0);
    for (int p = 0; p < NPIX; p++) send_word(16'd900, p, 1'b1, 1'b0);
    end_of_frame_check(fa0);

    repeat (4) @(negedge clock);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
